// File: rtl/div_16_seq_pkg.sv
// Shared definitions for the sequential restoring divider: widths, FSM states
// and the quotient reported on divide-by-zero.
package div_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_16_seq_if.sv
// Start/done request bus between the controlling FSM and the divider.
interface div_16_seq_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_16_seq_adder.sv
// Matrix-library add/subtract datapath; subtract=1 forms a - b with carry-out
// meaning "no borrow".
module sixtnBitAdder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin0,
  input  logic             subtract,
  output logic [WIDTH-1:0] sum_c,
  output logic             cout_c
);

  logic [WIDTH-1:0] b_eff_c;
  logic             cin_c;

  // Two's-complement subtract: invert b and force the carry-in.
  always_comb begin
    b_eff_c = b ^ {WIDTH{subtract}};
    cin_c   = cin0 | subtract;
  end

  assign {cout_c, sum_c} = (WIDTH + 1)'(a) + (WIDTH + 1)'(b_eff_c) + (WIDTH + 1)'(cin_c);

endmodule

// File: rtl/div_16_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake.
module div_16_seq
  import div_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  div_16_seq_if.slave  bus
);

  state_t             state_q, state_d;
  logic               accept_c;
  logic               dvs_zero_c;

  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic               dz_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               dbz_q;

  logic [WIDTH:0]     rem_shift_c;
  logic [WIDTH-1:0]   trial_c;
  logic               carry_c;
  logic               no_borrow_c;

  // Partial remainder with the next dividend bit shifted in; top bit is the guard.
  assign rem_shift_c = {rem_q, dvd_q[WIDTH-1]};

  sixtnBitAdder #(.WIDTH(WIDTH)) u_trial_sub (
    .a        (rem_shift_c[WIDTH-1:0]),
    .b        (dvs_q),
    .cin0     (1'b0),
    .subtract (1'b1),
    .sum_c    (trial_c),
    .cout_c   (carry_c)
  );

  // A set guard bit means the shifted remainder already exceeds any divisor.
  assign no_borrow_c = carry_c | rem_shift_c[WIDTH];
  assign dvs_zero_c  = (bus.divisor == '0);

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = dvs_zero_c ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Operand capture and one restoring step per CALC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dz_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept_c) begin
      dvd_q <= bus.dividend;
      dvs_q <= bus.divisor;
      cnt_q <= CNT_W'(WIDTH);
      dz_q  <= dvs_zero_c;
      quo_q <= dvs_zero_c ? DBZ_QUOTIENT : '0;
      rem_q <= dvs_zero_c ? bus.dividend : '0;
    end else if (state_q == ST_CALC) begin
      dvd_q <= dvd_q << 1;
      quo_q <= {quo_q[WIDTH-2:0], no_borrow_c};
      rem_q <= no_borrow_c ? trial_c : rem_shift_c[WIDTH-1:0];
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Results publish together with the done pulse; busy covers the pulse cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE) || (state_q == ST_DONE);
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        quotient_q  <= quo_q;
        remainder_q <= rem_q;
        dbz_q       <= dz_q;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_16_seq.sv
// Directed and randomized bench for div_16_seq against a plain-arithmetic model.
module tb_div_16_seq;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  div_16_seq_if bus();

  div_16_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the accept edge; returns edges until done is seen.
  task automatic wait_done(output int n, output logic busy_ok);
    n = 0;
    busy_ok = (bus.busy === 1'b1);
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done !== 1'b1) busy_ok = busy_ok & (bus.busy === 1'b1);
    end
    busy_ok = busy_ok & (bus.busy === 1'b1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] q32, r32;
    q32 = 32'(bus.quotient);
    r32 = 32'(bus.remainder);
    if (b == 16'd0) begin
      check({tag, " quotient"},  q32, 32'hFFFF);
      check({tag, " remainder"}, r32, 32'(a));
      check({tag, " dbz"},       32'(bus.div_by_zero), 32'd1);
    end else begin
      check({tag, " quotient"},  q32, 32'(a) / 32'(b));
      check({tag, " remainder"}, r32, 32'(a) % 32'(b));
      check({tag, " dbz"},       32'(bus.div_by_zero), 32'd0);
      check({tag, " identity"},  q32 * 32'(b) + r32, 32'(a));
      check({tag, " rem<div"},   32'(r32 < 32'(b)), 32'd1);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input string tag);
    int   n;
    logic busy_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 16'($urandom);
    wait_done(n, busy_ok);
    check({tag, " latency"}, 32'(n), (b == 16'd0) ? 32'd1 : 32'd17);
    check({tag, " busy held"}, 32'(busy_ok), 32'd1);
    check_result(tag, a, b);
    @(negedge clk);
    check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    check({tag, " busy fall"},  32'(bus.busy), 32'd0);
  endtask

  initial begin
    int          n;
    logic        busy_ok;
    logic        no_done;
    logic [15:0] a, b;

    reset_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    check("reset busy",      32'(bus.busy),        32'd0);
    check("reset done",      32'(bus.done),        32'd0);
    check("reset quotient",  32'(bus.quotient),    32'd0);
    check("reset remainder", 32'(bus.remainder),   32'd0);
    check("reset dbz",       32'(bus.div_by_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(16'd50,    16'd13,    "t1 50/13");
    do_op(16'd65535, 16'd1,     "t2 65535/1");
    do_op(16'd7,     16'd9,     "t2 7/9");
    do_op(16'd65535, 16'd65535, "t2 65535/65535");
    do_op(16'd1234,  16'd0,     "t3 1234/0");

    // Start while busy (mid-run and in the DONE cycle) is dropped; the edge after
    // the done pulse accepts.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    check("t4 no early done", 32'(bus.done), 32'd0);
    bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd3;
    @(negedge clk);
    check("t4 done", 32'(bus.done), 32'd1);
    check_result("t4 100/7", 16'd100, 16'd7);
    bus.dividend = 16'd50; bus.divisor = 16'd13;
    @(negedge clk);
    bus.start = 1'b0;
    check("t4 b2b busy", 32'(bus.busy), 32'd1);
    check("t4 b2b done", 32'(bus.done), 32'd0);
    wait_done(n, busy_ok);
    check("t4 b2b latency", 32'(n), 32'd17);
    check("t4 b2b busy held", 32'(busy_ok), 32'd1);
    check_result("t4 b2b 50/13", 16'd50, 16'd13);
    @(negedge clk);
    check("t4 b2b busy fall", 32'(bus.busy), 32'd0);

    // Reset in the middle of a division aborts it with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 16'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5 rst busy",      32'(bus.busy),        32'd0);
    check("t5 rst done",      32'(bus.done),        32'd0);
    check("t5 rst quotient",  32'(bus.quotient),    32'd0);
    check("t5 rst remainder", 32'(bus.remainder),   32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    no_done = 1'b1;
    repeat (20) begin
      @(negedge clk);
      no_done = no_done & (bus.done === 1'b0) & (bus.busy === 1'b0);
    end
    check("t5 no done after abort", 32'(no_done), 32'd1);
    do_op(16'd50, 16'd13, "t5 rerun 50/13");

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1, 2:    b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      do_op(a, b, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
